// File: rtl/pipe_stage_pkg.sv
// Shared definitions for the pipeline stage registers.
// Holds the occupancy/state encoding used by pipe_stage and the payload widths
// of each pipeline boundary, derived from the core's exec/reg/regAddr buses.
package pipe_stage_pkg;

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Existing core bus widths.
  localparam int unsigned EXEC_W     = 32;
  localparam int unsigned REG_W      = 32;
  localparam int unsigned REG_ADDR_W = 5;

  // Per-boundary payload widths (packed control + data fields).
  localparam int unsigned IFID_W  = 2 * EXEC_W;                    // pc + instr
  localparam int unsigned IDEX_W  = 2 * REG_W + EXEC_W + REG_ADDR_W; // rs1, rs2, imm, rd
  localparam int unsigned EXMEM_W = EXEC_W + REG_W + REG_ADDR_W;     // alu result, store data, rd
  localparam int unsigned MEMWB_W = REG_W + REG_ADDR_W;              // writeback data, rd

endpackage

// File: rtl/pipe_stage.sv
// Generic valid/ready pipeline stage register with flush and backpressure.
// SKID=1: two-entry skid buffer, in_ready decoded from registered state only.
// SKID=0: single entry, in_ready combinationally follows out_ready.
// ZERO_BUBBLE=1: data registers are cleared whenever their entry goes invalid,
// so out_data is all-zero exactly when out_valid is low.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   flush      drop all held entries and any same-cycle input
//   in_valid   upstream offers in_data
//   in_ready   stage can accept this cycle
//   in_data    upstream payload
//   out_valid  out_data holds a valid entry
//   out_ready  downstream consumes this cycle
//   out_data   head-entry payload
//   occupancy  number of held entries (0..2)
module pipe_stage
  import pipe_stage_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SKID        = 1,
  parameter int unsigned ZERO_BUBBLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  localparam bit Clear = (ZERO_BUBBLE != 0);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] w_main_nxt;
  logic             w_accept;
  logic             w_pop;

  // Flush suppresses both handshakes, so out_ready during flush is not a transfer.
  assign w_accept  = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  assign out_valid = (r_state != ST_EMPTY);
  assign out_data  = r_main;
  assign occupancy = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
    end
  end

  if (SKID != 0) begin : g_skid
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_skid_nxt;

    // Registered-state decode only: no path from out_ready.
    assign in_ready = (r_state != ST_TWO) && !rst;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_skid <= '0;
      end else begin
        r_skid <= w_skid_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
      if (flush) begin
        w_state_nxt = ST_EMPTY;
        if (Clear) begin
          w_main_nxt = '0;
          w_skid_nxt = '0;
        end
      end else begin
        unique case (r_state)
          ST_EMPTY: begin
            if (w_accept) begin
              w_state_nxt = ST_ONE;
              w_main_nxt  = in_data;
            end
          end
          ST_ONE: begin
            if (w_accept && w_pop) begin
              w_main_nxt = in_data;
            end else if (w_accept) begin
              w_state_nxt = ST_TWO;
              w_skid_nxt  = in_data;
            end else if (w_pop) begin
              w_state_nxt = ST_EMPTY;
              if (Clear) w_main_nxt = '0;
            end
          end
          ST_TWO: begin
            if (w_pop) begin
              w_state_nxt = ST_ONE;
              w_main_nxt  = r_skid;
              if (Clear) w_skid_nxt = '0;
            end
          end
          default: begin
            w_state_nxt = ST_EMPTY;
          end
        endcase
      end
    end
  end else begin : g_single
    assign in_ready = (!out_valid || out_ready) && !rst;

    always_comb begin
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
      if (flush) begin
        w_state_nxt = ST_EMPTY;
        if (Clear) w_main_nxt = '0;
      end else if (w_accept) begin
        // Covers accept-with-pop too: the held entry is simply replaced.
        w_state_nxt = ST_ONE;
        w_main_nxt  = in_data;
      end else if (w_pop) begin
        w_state_nxt = ST_EMPTY;
        if (Clear) w_main_nxt = '0;
      end else if (r_state == ST_TWO) begin
        w_state_nxt = ST_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: table-driven vectors on a SKID=1 copy,
// hand-written sequences for reset, SKID=0 and reset-during-flush, then a
// randomised FIFO scoreboard over all four SKID/ZERO_BUBBLE combinations.
module tb_pipe_stage;

  localparam int NDUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush     [NDUT];
  logic        in_valid  [NDUT];
  logic        in_ready  [NDUT];
  logic [31:0] in_data   [NDUT];
  logic        out_valid [NDUT];
  logic        out_ready [NDUT];
  logic [31:0] out_data  [NDUT];
  logic [1:0]  occupancy [NDUT];

  int n_pass   = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  // 0: skid + zero bubble, 1: single + zero bubble, 2: skid, 3: single
  pipe_stage #(.WIDTH(32), .SKID(1), .ZERO_BUBBLE(1)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .occupancy(occupancy[0]));
  pipe_stage #(.WIDTH(32), .SKID(0), .ZERO_BUBBLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .occupancy(occupancy[1]));
  pipe_stage #(.WIDTH(32), .SKID(1), .ZERO_BUBBLE(0)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .occupancy(occupancy[2]));
  pipe_stage #(.WIDTH(32), .SKID(0), .ZERO_BUBBLE(0)) u_dut3 (
    .clk(clk), .rst(rst), .flush(flush[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_data(in_data[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .out_data(out_data[3]), .occupancy(occupancy[3]));

  typedef struct {
    logic        v;
    logic        r;
    logic        f;
    logic [31:0] d;
    logic        exp_rdy;  // in_ready before the edge
    logic        exp_ov;   // after the edge
    logic [31:0] exp_od;
    logic [1:0]  exp_occ;
  } vec_t;

  vec_t vecs [18];

  logic [31:0] mq [NDUT][$];
  logic        mrdy [NDUT];

  function automatic bit is_skid(input int d);
    return (d == 0) || (d == 2);
  endfunction

  function automatic bit is_zb(input int d);
    return d < 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic idle_all();
    for (int d = 0; d < NDUT; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
      flush[d]     = 1'b0;
      in_data[d]   = 32'h0;
    end
  endtask

  task automatic apply_vec(input int i);
    @(negedge clk);
    in_valid[0]  = vecs[i].v;
    out_ready[0] = vecs[i].r;
    flush[0]     = vecs[i].f;
    in_data[0]   = vecs[i].d;
    #1;
    check($sformatf("vec%0d in_ready", i), 32'(in_ready[0]), 32'(vecs[i].exp_rdy));
    @(posedge clk);
    #1;
    check($sformatf("vec%0d out_valid", i), 32'(out_valid[0]), 32'(vecs[i].exp_ov));
    check($sformatf("vec%0d out_data", i), out_data[0], vecs[i].exp_od);
    check($sformatf("vec%0d occupancy", i), 32'(occupancy[0]), 32'(vecs[i].exp_occ));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    //            v  r  f  data    rdy ov  od      occ
    // streaming
    vecs[0]  = '{1, 1, 0, 32'd1,  1, 1, 32'd1,  2'd1};
    vecs[1]  = '{1, 1, 0, 32'd2,  1, 1, 32'd2,  2'd1};
    vecs[2]  = '{1, 1, 0, 32'd3,  1, 1, 32'd3,  2'd1};
    vecs[3]  = '{1, 1, 0, 32'd4,  1, 1, 32'd4,  2'd1};
    vecs[4]  = '{0, 1, 0, 32'd0,  1, 0, 32'd0,  2'd0};
    // backpressure: 10, 11 held, 12 stalls until drained
    vecs[5]  = '{1, 0, 0, 32'd10, 1, 1, 32'd10, 2'd1};
    vecs[6]  = '{1, 0, 0, 32'd11, 1, 1, 32'd10, 2'd2};
    vecs[7]  = '{1, 0, 0, 32'd12, 0, 1, 32'd10, 2'd2};
    vecs[8]  = '{1, 1, 0, 32'd12, 0, 1, 32'd11, 2'd1};
    vecs[9]  = '{1, 1, 0, 32'd12, 1, 1, 32'd12, 2'd1};
    vecs[10] = '{0, 1, 0, 32'd0,  1, 0, 32'd0,  2'd0};
    // flush from TWO with a same-cycle offer of 7
    vecs[11] = '{1, 0, 0, 32'd5,  1, 1, 32'd5,  2'd1};
    vecs[12] = '{1, 0, 0, 32'd6,  1, 1, 32'd5,  2'd2};
    vecs[13] = '{1, 1, 1, 32'd7,  0, 0, 32'd0,  2'd0};
    vecs[14] = '{0, 0, 0, 32'd0,  1, 0, 32'd0,  2'd0};
    // flush from ONE with a same-cycle offer
    vecs[15] = '{1, 0, 0, 32'd8,  1, 1, 32'd8,  2'd1};
    vecs[16] = '{1, 0, 1, 32'd9,  1, 0, 32'd0,  2'd0};
    vecs[17] = '{0, 1, 0, 32'd0,  1, 0, 32'd0,  2'd0};

    // Reset held for 3 cycles while offering data
    rst = 1'b1;
    idle_all();
    for (int d = 0; d < NDUT; d++) begin
      in_valid[d] = 1'b1;
      in_data[d]  = 32'hDEADBEEF;
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        check($sformatf("rst%0d dut%0d out_valid", c, d), 32'(out_valid[d]), 32'd0);
        check($sformatf("rst%0d dut%0d out_data", c, d), out_data[d], 32'd0);
        check($sformatf("rst%0d dut%0d in_ready", c, d), 32'(in_ready[d]), 32'd0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    idle_all();
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("post-rst dut%0d in_ready", d), 32'(in_ready[d]), 32'd1);
      check($sformatf("post-rst dut%0d occupancy", d), 32'(occupancy[d]), 32'd0);
    end

    for (int i = 0; i < 18; i++) apply_vec(i);
    idle_all();

    // SKID=0: ready follows out_ready in the same cycle; accept+pop replaces
    @(negedge clk);
    in_valid[1] = 1'b1; in_data[1] = 32'd8; out_ready[1] = 1'b0;
    @(posedge clk);
    #1;
    check("s0 hold out_data", out_data[1], 32'd8);
    check("s0 hold occupancy", 32'(occupancy[1]), 32'd1);
    @(negedge clk);
    in_valid[1] = 1'b1; in_data[1] = 32'd9; out_ready[1] = 1'b0;
    #1;
    check("s0 stalled in_ready", 32'(in_ready[1]), 32'd0);
    out_ready[1] = 1'b1;
    #1;
    check("s0 comb in_ready", 32'(in_ready[1]), 32'd1);
    @(posedge clk);
    #1;
    check("s0 replace out_valid", 32'(out_valid[1]), 32'd1);
    check("s0 replace out_data", out_data[1], 32'd9);
    check("s0 replace occupancy", 32'(occupancy[1]), 32'd1);
    @(negedge clk);
    in_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    check("s0 drain out_valid", 32'(out_valid[1]), 32'd0);
    check("s0 drain out_data", out_data[1], 32'd0);

    // rst together with flush while full: everything lost, rst wins
    @(negedge clk);
    idle_all();
    in_valid[0] = 1'b1; in_data[0] = 32'd21;
    @(negedge clk);
    in_data[0] = 32'd22;
    @(posedge clk);
    #1;
    check("rstmid full occupancy", 32'(occupancy[0]), 32'd2);
    @(negedge clk);
    rst = 1'b1; flush[0] = 1'b1; in_data[0] = 32'd23; out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid out_valid", 32'(out_valid[0]), 32'd0);
    check("rstmid out_data", out_data[0], 32'd0);
    check("rstmid occupancy", 32'(occupancy[0]), 32'd0);
    check("rstmid in_ready", 32'(in_ready[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_all();
    #1;
    check("rstmid release in_ready", 32'(in_ready[0]), 32'd1);

    // Random valid/ready/flush against a FIFO scoreboard, all four variants
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        in_valid[d]  = ($urandom_range(0, 9) < 7);
        out_ready[d] = ($urandom_range(0, 9) < 6);
        flush[d]     = ($urandom_range(0, 19) == 0);
        in_data[d]   = $urandom;
        if (is_skid(d)) mrdy[d] = (mq[d].size() < 2);
        else mrdy[d] = (mq[d].size() == 0) || out_ready[d];
      end
      #1;
      for (int d = 0; d < NDUT; d++) begin
        check($sformatf("rnd%0d dut%0d in_ready", cyc, d), 32'(in_ready[d]), 32'(mrdy[d]));
        check($sformatf("rnd%0d dut%0d out_valid", cyc, d), 32'(out_valid[d]),
              32'(mq[d].size() != 0));
        check($sformatf("rnd%0d dut%0d occupancy", cyc, d), 32'(occupancy[d]),
              32'(mq[d].size()));
        if (mq[d].size() != 0)
          check($sformatf("rnd%0d dut%0d out_data", cyc, d), out_data[d], mq[d][0]);
        else if (is_zb(d))
          check($sformatf("rnd%0d dut%0d bubble data", cyc, d), out_data[d], 32'd0);
      end
      @(posedge clk);
      for (int d = 0; d < NDUT; d++) begin
        if (flush[d]) begin
          mq[d].delete();
        end else begin
          if ((mq[d].size() != 0) && out_ready[d]) void'(mq[d].pop_front());
          if (in_valid[d] && mrdy[d]) mq[d].push_back(in_data[d]);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Generic parametrised pipeline stage register that replaces the hand-written per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one valid/ready-handshaked block. It carries an opaque WIDTH-bit payload and supports flush (bubble insertion) and backpressure. An optional two-entry skid buffer breaks the combinational ready path between stages. Each pipeline boundary in the core instantiates one copy, with the stage's packed control and data fields as the payload.

## Interface
Parameters:
- WIDTH, 32: payload width in bits, minimum 1.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- ZERO_BUBBLE, 1: 1 = out_data forced to all-zero whenever out_valid=0 (bubbles decode as NOP, write-enable low); 0 = out_data undefined when invalid.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all held entries and any same-cycle input.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data holds a valid entry.
- out_ready  in  1  downstream consumes this cycle.
- out_data  out  WIDTH  head-entry payload.
- occupancy  out  2  number of held entries (0..2; max 1 when SKID=0).

## Operation
- Accept: in_valid && in_ready && !flush on a rising edge.
- Pop: out_valid && out_ready && !flush on a rising edge.
- Ordering: FIFO; no entry is duplicated or dropped except by flush or rst.
- SKID=1 state machine, states EMPTY, ONE, TWO:
  - EMPTY: accept moves to ONE, payload written to main.
  - ONE with accept and pop: stays ONE, main is overwritten.
  - ONE with accept only: moves to TWO, payload written to skid.
  - ONE with pop only: moves to EMPTY.
  - TWO with pop: skid moves to main, state becomes ONE.
  - TWO never accepts.
- SKID=1 ready: in_ready = (state != TWO) && !rst. It is a decode of registered state only, with no combinational path from out_ready.
- SKID=0: single entry. in_ready = (!out_valid || out_ready) && !rst. Simultaneous accept and pop replaces the entry.
- Flush: the next state is EMPTY and both valids are cleared. Any accept or pop in the flush cycle does not happen; downstream must not treat out_ready in the flush cycle as a completed transfer. Flush takes priority over everything except rst.
- ZERO_BUBBLE=1:
  - Each data register is cleared whenever its entry becomes invalid: on pop-to-empty, on flush and on rst.
  - Consequence: out_data == 0 exactly whenever out_valid == 0.
- Outputs:
  - out_valid = (state != EMPTY).
  - out_data = main register.
  - occupancy = state encoding: EMPTY=0, ONE=1, TWO=2.

## Timing
- Reset values: out_valid=0, out_data=0, occupancy=0, state EMPTY. in_ready=0 while rst is high and 1 in the first cycle after rst is deasserted.
- Latency: data accepted at edge N appears on out_data/out_valid after edge N, i.e. one cycle.
- Throughput: one transfer per cycle sustained in both modes when out_ready is held high.
- SKID=1 backpressure: out_ready dropping while in ONE still accepts one more entry, into skid. in_ready falls the cycle after entering TWO.
- rst or flush asserted mid-operation: all entries are lost at that edge, with no partial update.
- Simultaneous rst and flush: rst behaviour applies.

## Structure
- The shared package holds:
  - the state encoding constants ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2;
  - the per-stage payload width constants, e.g. IDEX_W and EXMEM_W, derived from the existing exec/reg/regAddr bus widths.
- No sub-module. The SKID=0 and SKID=1 paths are selected with a generate block inside pipe_stage.
- Stall-unit integration per boundary:
  - a stage stall maps to out_ready=0 on the upstream copy;
  - the existing "stall[k] && !stall[k+1]" bubble case maps to in_valid=0 on the downstream copy;
  - branch mispredict drives flush.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1, in_data=32'hDEADBEEF -> out_valid=0, out_data=0, in_ready=0. After release in_ready=1 and occupancy=0.
- Streaming, SKID=1: out_ready=1, send 1,2,3,4 on consecutive cycles -> out_data reads 1,2,3,4 one cycle later each, occupancy never exceeds 1.
- Backpressure, SKID=1: send 10,11,12 with out_ready=0 -> 10 and 11 held, occupancy=2, in_ready=0, 12 stalls upstream. Raise out_ready -> 10, 11, 12 emerge in order with no loss.
- Flush: state TWO holding 5 and 6, assert flush with in_valid=1, in_data=7 -> next cycle out_valid=0, out_data=0, occupancy=0, and 7 never appears.
- SKID=0 pass-through: out_ready=0 with one entry held -> in_ready=0 in the same cycle. Simultaneous accept 9 and pop 8 -> out_data=9 next cycle, occupancy=1.
- ZERO_BUBBLE=0 regression: pop to empty -> out_valid=0 with out_data unchecked; random valid/ready/flush for 10k cycles against a FIFO scoreboard shows no drops or duplications.
